// File: rtl/unidade_controle_rodadas.sv
// Moore control unit for the round-mode memory game: shows the sequence up to
// the round limit, then collects, registers and compares each player jogada.
module unidade_controle_rodadas #(
  parameter logic TIMEOUT_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  input  logic       fimT,
  input  logic       timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraTO,
  output logic       contaTO,
  output logic       mostraLed,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       perdeu_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL         = 4'h0,
    PREPARACAO      = 4'h1,
    INICIA_RODADA   = 4'h2,
    MOSTRA_ITEM     = 4'h3,
    APAGA_ITEM      = 4'h4,
    INTERVALO       = 4'h5,
    PROXIMO_ITEM    = 4'h6,
    INICIA_JOGADAS  = 4'h7,
    ESPERA_JOGADA   = 4'h8,
    REGISTRA_JOGADA = 4'h9,
    COMPARA_JOGADA  = 4'hA,
    PROXIMA_JOGADA  = 4'hB,
    PROXIMA_RODADA  = 4'hC,
    FINAL_TIMEOUT   = 4'hD,
    FINAL_ACERTOU   = 4'hE,
    FINAL_ERROU     = 4'hF
  } estado_t;

  // Output vector bit order:
  // {zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
  //  zeraTO, contaTO, mostraLed, pronto, acertou, errou, perdeu_timeout}
  localparam logic [14:0] S_ZERA_TUDO = 15'b101010101000000;

  estado_t     estado_r;
  estado_t     proximo_s;
  logic [14:0] saidas_r;

  function automatic logic [14:0] decodifica(input estado_t e);
    logic [14:0] s;
    case (e)
      INICIAL:         s = S_ZERA_TUDO;
      PREPARACAO:      s = S_ZERA_TUDO;
      INICIA_RODADA:   s = 15'b100000100000000;
      MOSTRA_ITEM:     s = 15'b000000010010000;
      APAGA_ITEM:      s = 15'b000000100000000;
      INTERVALO:       s = 15'b000000010000000;
      PROXIMO_ITEM:    s = 15'b010000100000000;
      INICIA_JOGADAS:  s = 15'b100000001000000;
      ESPERA_JOGADA:   s = 15'b000000000100000;
      REGISTRA_JOGADA: s = 15'b000001000000000;
      COMPARA_JOGADA:  s = 15'b000000000000000;
      PROXIMA_JOGADA:  s = 15'b010000001000000;
      PROXIMA_RODADA:  s = 15'b000100000000000;
      FINAL_TIMEOUT:   s = 15'b000000000001001;
      FINAL_ACERTOU:   s = 15'b000000000001100;
      FINAL_ERROU:     s = 15'b000000000001010;
      default:         s = S_ZERA_TUDO;
    endcase
    return s;
  endfunction

  // State register with asynchronous clear to inicial.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r <= INICIAL;
    end else begin
      estado_r <= proximo_s;
    end
  end

  // Outputs are registered from the next state so they always match estado_r.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      saidas_r <= S_ZERA_TUDO;
    end else begin
      saidas_r <= decodifica(proximo_s);
    end
  end

  // Next-state logic.
  always_comb begin
    proximo_s = estado_r;
    case (estado_r)
      INICIAL:         proximo_s = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:      proximo_s = INICIA_RODADA;
      INICIA_RODADA:   proximo_s = MOSTRA_ITEM;
      MOSTRA_ITEM:     proximo_s = fimT ? APAGA_ITEM : MOSTRA_ITEM;
      APAGA_ITEM:      proximo_s = INTERVALO;
      INTERVALO: begin
        if (fimT) begin
          proximo_s = fimE ? INICIA_JOGADAS : PROXIMO_ITEM;
        end else begin
          proximo_s = INTERVALO;
        end
      end
      PROXIMO_ITEM:    proximo_s = MOSTRA_ITEM;
      INICIA_JOGADAS:  proximo_s = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // A jogada arriving with the timeout still counts.
        if (jogada) begin
          proximo_s = REGISTRA_JOGADA;
        end else if (timeout && TIMEOUT_EN) begin
          proximo_s = FINAL_TIMEOUT;
        end else begin
          proximo_s = ESPERA_JOGADA;
        end
      end
      REGISTRA_JOGADA: proximo_s = COMPARA_JOGADA;
      COMPARA_JOGADA: begin
        if (!igual) begin
          proximo_s = FINAL_ERROU;
        end else if (!fimE) begin
          proximo_s = PROXIMA_JOGADA;
        end else if (!fimL) begin
          proximo_s = PROXIMA_RODADA;
        end else begin
          proximo_s = FINAL_ACERTOU;
        end
      end
      PROXIMA_JOGADA:  proximo_s = ESPERA_JOGADA;
      PROXIMA_RODADA:  proximo_s = INICIA_RODADA;
      FINAL_TIMEOUT:   proximo_s = iniciar ? PREPARACAO : FINAL_TIMEOUT;
      FINAL_ACERTOU:   proximo_s = iniciar ? PREPARACAO : FINAL_ACERTOU;
      FINAL_ERROU:     proximo_s = iniciar ? PREPARACAO : FINAL_ERROU;
      default:         proximo_s = INICIAL;
    endcase
  end

  assign {zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
          zeraTO, contaTO, mostraLed, pronto, acertou, errou,
          perdeu_timeout} = saidas_r;
  assign db_estado = estado_r;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Directed bench for unidade_controle_rodadas; two instances cover both
// TIMEOUT_EN settings driven by the same stimulus.
module tb_unidade_controle_rodadas;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0, jogada = 1'b0, igual = 1'b0, fimE = 1'b0;
  logic fimL = 1'b0, fimT = 1'b0, timeout = 1'b0;

  logic zeraE_a, contaE_a, zeraL_a, contaL_a, zeraR_a, registraR_a, zeraT_a;
  logic contaT_a, zeraTO_a, contaTO_a, mostraLed_a, pronto_a, acertou_a;
  logic errou_a, perdeu_a;
  logic [3:0] estado_a;
  logic zeraE_b, contaE_b, zeraL_b, contaL_b, zeraR_b, registraR_b, zeraT_b;
  logic contaT_b, zeraTO_b, contaTO_b, mostraLed_b, pronto_b, acertou_b;
  logic errou_b, perdeu_b;
  logic [3:0] estado_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  unidade_controle_rodadas #(.TIMEOUT_EN(1'b1)) dut_a (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fimE(fimE), .fimL(fimL), .fimT(fimT), .timeout(timeout),
    .zeraE(zeraE_a), .contaE(contaE_a), .zeraL(zeraL_a), .contaL(contaL_a),
    .zeraR(zeraR_a), .registraR(registraR_a), .zeraT(zeraT_a),
    .contaT(contaT_a), .zeraTO(zeraTO_a), .contaTO(contaTO_a),
    .mostraLed(mostraLed_a), .pronto(pronto_a), .acertou(acertou_a),
    .errou(errou_a), .perdeu_timeout(perdeu_a), .db_estado(estado_a)
  );

  unidade_controle_rodadas #(.TIMEOUT_EN(1'b0)) dut_b (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fimE(fimE), .fimL(fimL), .fimT(fimT), .timeout(timeout),
    .zeraE(zeraE_b), .contaE(contaE_b), .zeraL(zeraL_b), .contaL(contaL_b),
    .zeraR(zeraR_b), .registraR(registraR_b), .zeraT(zeraT_b),
    .contaT(contaT_b), .zeraTO(zeraTO_b), .contaTO(contaTO_b),
    .mostraLed(mostraLed_b), .pronto(pronto_b), .acertou(acertou_b),
    .errou(errou_b), .perdeu_timeout(perdeu_b), .db_estado(estado_b)
  );

  wire [14:0] out_a = {zeraE_a, contaE_a, zeraL_a, contaL_a, zeraR_a,
                       registraR_a, zeraT_a, contaT_a, zeraTO_a, contaTO_a,
                       mostraLed_a, pronto_a, acertou_a, errou_a, perdeu_a};
  wire [14:0] out_b = {zeraE_b, contaE_b, zeraL_b, contaL_b, zeraR_b,
                       registraR_b, zeraT_b, contaT_b, zeraTO_b, contaTO_b,
                       mostraLed_b, pronto_b, acertou_b, errou_b, perdeu_b};

  // Expected outputs per state, written from the state table.
  // Bit order: zE cE zL cL zR rR zT cT zTO cTO led pronto acertou errou perdeu
  function automatic logic [14:0] esperado(input logic [3:0] s);
    case (s)
      4'h0, 4'h1: return 15'b101010101000000;
      4'h2: return 15'b100000100000000;
      4'h3: return 15'b000000010010000;
      4'h4: return 15'b000000100000000;
      4'h5: return 15'b000000010000000;
      4'h6: return 15'b010000100000000;
      4'h7: return 15'b100000001000000;
      4'h8: return 15'b000000000100000;
      4'h9: return 15'b000001000000000;
      4'hA: return 15'b000000000000000;
      4'hB: return 15'b010000001000000;
      4'hC: return 15'b000100000000000;
      4'hD: return 15'b000000000001001;
      4'hE: return 15'b000000000001100;
      default: return 15'b000000000001010;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Input bits: {iniciar, jogada, igual, fimE, fimL, fimT, timeout}
  localparam logic [6:0] INI = 7'h40, JOG = 7'h20, IGU = 7'h10, FE = 7'h08;
  localparam logic [6:0] FL = 7'h04, FT = 7'h02, TO = 7'h01, NADA = 7'h00;

  typedef struct {
    logic [6:0] in;
    logic [3:0] ea;
    logic [3:0] eb;
  } vec_t;

  vec_t vecs[53];

  task automatic aplica(input logic [6:0] v);
    {iniciar, jogada, igual, fimE, fimL, fimT, timeout} = v;
    @(posedge clock);
    #1;
  endtask

  task automatic confere(input string tag, input logic [3:0] ea,
                         input logic [3:0] eb);
    check({tag, " estado_a"}, {28'd0, estado_a}, {28'd0, ea});
    check({tag, " saidas_a"}, {17'd0, out_a}, {17'd0, esperado(ea)});
    check({tag, " estado_b"}, {28'd0, estado_b}, {28'd0, eb});
    check({tag, " saidas_b"}, {17'd0, out_b}, {17'd0, esperado(eb)});
  endtask

  initial begin
    vecs[0]  = '{NADA, 4'h0, 4'h0};
    vecs[1]  = '{NADA, 4'h0, 4'h0};
    vecs[2]  = '{INI, 4'h1, 4'h1};
    vecs[3]  = '{INI, 4'h2, 4'h2};          // preparacao ignores held iniciar
    vecs[4]  = '{NADA, 4'h3, 4'h3};
    vecs[5]  = '{NADA, 4'h3, 4'h3};
    vecs[6]  = '{FT, 4'h4, 4'h4};
    vecs[7]  = '{NADA, 4'h5, 4'h5};
    vecs[8]  = '{FE, 4'h5, 4'h5};
    vecs[9]  = '{FT | FE, 4'h7, 4'h7};
    vecs[10] = '{NADA, 4'h8, 4'h8};
    vecs[11] = '{JOG | TO, 4'h9, 4'h9};     // jogada beats timeout
    vecs[12] = '{NADA, 4'hA, 4'hA};
    vecs[13] = '{IGU | FE, 4'hC, 4'hC};
    vecs[14] = '{INI, 4'h2, 4'h2};
    vecs[15] = '{NADA, 4'h3, 4'h3};
    vecs[16] = '{FT, 4'h4, 4'h4};
    vecs[17] = '{NADA, 4'h5, 4'h5};
    vecs[18] = '{FT, 4'h6, 4'h6};
    vecs[19] = '{INI, 4'h3, 4'h3};
    vecs[20] = '{FT, 4'h4, 4'h4};
    vecs[21] = '{NADA, 4'h5, 4'h5};
    vecs[22] = '{FT | FE, 4'h7, 4'h7};
    vecs[23] = '{NADA, 4'h8, 4'h8};
    vecs[24] = '{INI, 4'h8, 4'h8};
    vecs[25] = '{JOG, 4'h9, 4'h9};
    vecs[26] = '{NADA, 4'hA, 4'hA};
    vecs[27] = '{IGU, 4'hB, 4'hB};
    vecs[28] = '{NADA, 4'h8, 4'h8};
    vecs[29] = '{JOG, 4'h9, 4'h9};
    vecs[30] = '{NADA, 4'hA, 4'hA};
    vecs[31] = '{FE | FL, 4'hF, 4'hF};
    vecs[32] = '{NADA, 4'hF, 4'hF};
    vecs[33] = '{INI, 4'h1, 4'h1};
    vecs[34] = '{NADA, 4'h2, 4'h2};
    vecs[35] = '{NADA, 4'h3, 4'h3};
    vecs[36] = '{FT, 4'h4, 4'h4};
    vecs[37] = '{NADA, 4'h5, 4'h5};
    vecs[38] = '{FT | FE, 4'h7, 4'h7};
    vecs[39] = '{NADA, 4'h8, 4'h8};
    vecs[40] = '{TO, 4'hD, 4'h8};           // timeout only matters when enabled
    vecs[41] = '{NADA, 4'hD, 4'h8};
    vecs[42] = '{INI, 4'h1, 4'h8};
    vecs[43] = '{NADA, 4'h2, 4'h8};
    vecs[44] = '{NADA, 4'h3, 4'h8};
    vecs[45] = '{FT, 4'h4, 4'h8};
    vecs[46] = '{NADA, 4'h5, 4'h8};
    vecs[47] = '{FT | FE, 4'h7, 4'h8};
    vecs[48] = '{NADA, 4'h8, 4'h8};
    vecs[49] = '{JOG, 4'h9, 4'h9};
    vecs[50] = '{NADA, 4'hA, 4'hA};
    vecs[51] = '{IGU | FE | FL, 4'hE, 4'hE};
    vecs[52] = '{NADA, 4'hE, 4'hE};

    // Reset held for three edges.
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    confere("reset", 4'h0, 4'h0);
    reset = 1'b1;

    for (int i = 0; i < 53; i++) begin
      aplica(vecs[i].in);
      confere($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb);
    end

    // Restart from final_acertou and walk to intervalo.
    aplica(INI);
    aplica(NADA);
    aplica(NADA);
    aplica(FT);
    aplica(NADA);
    confere("pre_reset", 4'h5, 4'h5);

    // Asynchronous reset between edges, then held across an edge.
    #2;
    reset = 1'b0;
    #1;
    confere("async_reset", 4'h0, 4'h0);
    aplica(INI);
    confere("reset_hold", 4'h0, 4'h0);
    reset = 1'b1;
    aplica(INI);
    confere("after_reset", 4'h1, 4'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
